// File: rtl/awg_pkg.sv
// awg_pkg: shared ASCII codes, field widths, limits and FSM states for the AWG command controller.
package awg_pkg;
  localparam logic [7:0] KEY_W = 8'h57;
  localparam logic [7:0] KEY_F = 8'h46;
  localparam logic [7:0] KEY_A = 8'h41;
  localparam logic [7:0] KEY_P = 8'h50;
  localparam logic [7:0] KEY_R = 8'h52;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h45;
  localparam int WAVE_W = 3;
  localparam int FREQ_W = 12;
  localparam int AMP_W = 4;
  localparam int PHASE_W = 8;
  localparam int ACC_W = 14;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] LIM_W = 3'd1;
  localparam logic [CNT_W-1:0] LIM_F = 3'd4;
  localparam logic [CNT_W-1:0] LIM_A = 3'd2;
  localparam logic [CNT_W-1:0] LIM_P = 3'd3;
  localparam logic [CNT_W-1:0] LIM_R = 3'd0;
  localparam logic [ACC_W-1:0] MIN_FREQ = 14'd1;
  localparam logic [ACC_W-1:0] MAX_FREQ = 14'd4095;
  localparam logic [ACC_W-1:0] MAX_AMP = 14'd15;
  localparam logic [ACC_W-1:0] MAX_PHASE = 14'd255;
  typedef enum logic [2:0] {S_IDLE, S_DIGITS, S_DISCARD, S_CHECK, S_RESP} state_t;
  function automatic logic is_key(input logic [7:0] b);
    return b == KEY_W || b == KEY_F || b == KEY_A || b == KEY_P || b == KEY_R;
  endfunction
  function automatic logic is_term(input logic [7:0] b);
    return b == CR || b == LF;
  endfunction
  function automatic logic [CNT_W-1:0] key_limit(input logic [7:0] k);
    return k == KEY_W ? LIM_W : k == KEY_F ? LIM_F : k == KEY_A ? LIM_A : k == KEY_P ? LIM_P : LIM_R;
  endfunction
endpackage

// File: rtl/awg_dec_acc.sv
// awg_dec_acc: ASCII digit decode and decimal accumulate with digit count and limit flag.
module awg_dec_acc
  import awg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_byte,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_is_digit,
  output logic             o_at_limit,
  output logic [ACC_W-1:0] o_acc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  assign o_is_digit = i_byte >= 8'h30 && i_byte <= 8'h39;
  assign o_at_limit = r_cnt == i_limit;
  assign o_acc = r_acc;
  assign o_cnt = r_cnt;
  // digit limits keep acc*10+d within 9999, so the shifts never overflow
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= (r_acc << 3) + (r_acc << 1) + ACC_W'(i_byte[3:0]);
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/awg_cmd_ctrl.sv
// awg_cmd_ctrl: parses framed ASCII UART commands, range-checks and commits AWG config, replies K/E.
module awg_cmd_ctrl
  import awg_pkg::*;
#(
  parameter int NUM_WAVES   = 5,
  parameter int DEF_WAVE    = 0,
  parameter int DEF_FREQ    = 1,
  parameter int DEF_AMP     = 15,
  parameter int DEF_PHASE   = 0,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [WAVE_W-1:0]  cfg_wave,
  output logic [FREQ_W-1:0]  cfg_freq,
  output logic [AMP_W-1:0]   cfg_amp,
  output logic [PHASE_W-1:0] cfg_phase,
  output logic               cfg_update,
  output logic               rx_drop
);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAVE_W-1:0] DW = WAVE_W'(DEF_WAVE);
  localparam logic [FREQ_W-1:0] DF = FREQ_W'(DEF_FREQ);
  localparam logic [AMP_W-1:0] DA = AMP_W'(DEF_AMP);
  localparam logic [PHASE_W-1:0] DP = PHASE_W'(DEF_PHASE);
  state_t r_state, w_next;
  logic [7:0] r_key;
  logic [TO_W-1:0] r_to;
  logic w_is_digit, w_at_limit, w_clr, w_en, w_term, w_key, w_pass, w_timeout, w_wait;
  logic [ACC_W-1:0] w_acc;
  logic [CNT_W-1:0] w_cnt;
  assign w_term = rx_valid && is_term(rx_data);
  assign w_key = rx_valid && is_key(rx_data);
  assign w_clr = r_state == S_IDLE && w_key;
  assign w_en = r_state == S_DIGITS && rx_valid && w_is_digit && !w_at_limit;
  assign w_wait = (r_state == S_DIGITS || r_state == S_DISCARD) && !rx_valid;
  assign w_timeout = w_wait && r_to == TO_W'(TIMEOUT_CYC - 1);
  assign w_pass = r_key == KEY_R ? w_cnt == '0 : w_cnt != '0 && (
                  r_key == KEY_W ? w_acc < ACC_W'(NUM_WAVES) :
                  r_key == KEY_F ? w_acc >= MIN_FREQ && w_acc <= MAX_FREQ :
                  r_key == KEY_A ? w_acc <= MAX_AMP : w_acc <= MAX_PHASE);
  awg_dec_acc u_dec (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_en       (w_en),
    .i_byte     (rx_data),
    .i_limit    (key_limit(r_key)),
    .o_is_digit (w_is_digit),
    .o_at_limit (w_at_limit),
    .o_acc      (w_acc),
    .o_cnt      (w_cnt)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = rx_valid && !w_term ? (w_key ? S_DIGITS : S_DISCARD) : S_IDLE;
      S_DIGITS:  w_next = w_timeout ? S_IDLE : !rx_valid ? S_DIGITS : w_term ? S_CHECK :
                          (w_is_digit && !w_at_limit) ? S_DIGITS : S_DISCARD;
      S_DISCARD: w_next = w_timeout ? S_IDLE : w_term ? S_RESP : S_DISCARD;
      S_CHECK:   w_next = S_RESP;
      S_RESP:    w_next = tx_valid && tx_ready ? S_IDLE : S_RESP;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_key <= '0;
      r_to <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      cfg_wave <= DW;
      cfg_freq <= DF;
      cfg_amp <= DA;
      cfg_phase <= DP;
      cfg_update <= 1'b0;
      rx_drop <= 1'b0;
    end else begin
      r_state <= w_next;
      cfg_update <= 1'b0;
      r_to <= w_wait && !w_timeout ? r_to + 1'b1 : '0;
      if (w_clr) r_key <= rx_data;
      if (rx_valid && (r_state == S_RESP || r_state == S_CHECK)) rx_drop <= 1'b1;
      if (r_state == S_DISCARD && w_term) begin
        tx_valid <= 1'b1;
        tx_data <= NAK;
      end
      if (r_state == S_CHECK) begin
        tx_valid <= 1'b1;
        tx_data <= w_pass ? ACK : NAK;
        cfg_update <= w_pass;
        if (w_pass) begin
          if (r_key == KEY_W || r_key == KEY_R) cfg_wave <= r_key == KEY_R ? DW : w_acc[WAVE_W-1:0];
          if (r_key == KEY_F || r_key == KEY_R) cfg_freq <= r_key == KEY_R ? DF : w_acc[FREQ_W-1:0];
          if (r_key == KEY_A || r_key == KEY_R) cfg_amp <= r_key == KEY_R ? DA : w_acc[AMP_W-1:0];
          if (r_key == KEY_P || r_key == KEY_R) cfg_phase <= r_key == KEY_R ? DP : w_acc[PHASE_W-1:0];
        end
      end
      if (r_state == S_RESP && tx_ready) tx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// tb_awg_cmd_ctrl: table-driven frames plus hand sequences for latency, timeout, backpressure and reset.
module tb_awg_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_valid = 1'b0;
  logic tx_ready = 1'b1;
  logic [7:0] tx_data;
  logic tx_valid;
  logic [2:0] cfg_wave;
  logic [11:0] cfg_freq;
  logic [3:0] cfg_amp;
  logic [7:0] cfg_phase;
  logic cfg_update;
  logic rx_drop;
  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  int upd_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  localparam int TO = 40;
  typedef struct {
    string s;
    int hs;
    logic [7:0] tx;
    int upd;
    int wave;
    int freq;
    int amp;
    int phase;
  } vec_t;
  vec_t tbl[15];
  awg_cmd_ctrl #(.NUM_WAVES(5), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cfg_wave   (cfg_wave),
    .cfg_freq   (cfg_freq),
    .cfg_amp    (cfg_amp),
    .cfg_phase  (cfg_phase),
    .cfg_update (cfg_update),
    .rx_drop    (rx_drop)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      hs_cnt <= hs_cnt + 1;
      last_tx <= tx_data;
    end
    if (cfg_update) upd_cnt <= upd_cnt + 1;
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data = 8'h00;
    tick(2);
  endtask
  task automatic check_cfg(input string name, input int w, input int f, input int a, input int p);
    check({name, ".wave"}, 32'(cfg_wave), w);
    check({name, ".freq"}, 32'(cfg_freq), f);
    check({name, ".amp"}, 32'(cfg_amp), a);
    check({name, ".phase"}, 32'(cfg_phase), p);
  endtask
  task automatic apply(input vec_t v);
    int h0, u0;
    h0 = hs_cnt;
    u0 = upd_cnt;
    for (int i = 0; i < v.s.len(); i++) send_byte(v.s[i]);
    tick(6);
    check({v.s, " handshakes"}, hs_cnt - h0, v.hs);
    if (v.hs != 0) check({v.s, " tx_data"}, 32'(last_tx), 32'(v.tx));
    check({v.s, " updates"}, upd_cnt - u0, v.upd);
    check({v.s, " tx_valid"}, 32'(tx_valid), 0);
    check_cfg(v.s, v.wave, v.freq, v.amp, v.phase);
  endtask
  initial begin
    int h0, u0;
    tbl[0]  = '{"A16\015",   1, 8'h45, 0, 0, 1000, 15, 0};
    tbl[1]  = '{"W5\015",    1, 8'h45, 0, 0, 1000, 15, 0};
    tbl[2]  = '{"F0\015",    1, 8'h45, 0, 0, 1000, 15, 0};
    tbl[3]  = '{"P1234\n",   1, 8'h45, 0, 0, 1000, 15, 0};
    tbl[4]  = '{"Px\n",      1, 8'h45, 0, 0, 1000, 15, 0};
    tbl[5]  = '{"P255\n",    1, 8'h4B, 1, 0, 1000, 15, 255};
    tbl[6]  = '{"\015",      0, 8'h00, 0, 0, 1000, 15, 255};
    tbl[7]  = '{"w1\n",      1, 8'h45, 0, 0, 1000, 15, 255};
    tbl[8]  = '{"W4\n",      1, 8'h4B, 1, 4, 1000, 15, 255};
    tbl[9]  = '{"F4095\n",   1, 8'h4B, 1, 4, 4095, 15, 255};
    tbl[10] = '{"F4096\n",   1, 8'h45, 0, 4, 4095, 15, 255};
    tbl[11] = '{"A\n",       1, 8'h45, 0, 4, 4095, 15, 255};
    tbl[12] = '{"A00\015",   1, 8'h4B, 1, 4, 4095, 0, 255};
    tbl[13] = '{"R5\n",      1, 8'h45, 0, 4, 4095, 0, 255};
    tbl[14] = '{"P255\n",    1, 8'h4B, 1, 4, 4095, 0, 255};
    tick(3);
    rst = 1'b0;
    tick(10);
    check_cfg("reset", 0, 1, 15, 0);
    check("reset tx_valid", 32'(tx_valid), 0);
    check("reset cfg_update", 32'(cfg_update), 0);
    check("reset rx_drop", 32'(rx_drop), 0);
    u0 = upd_cnt;
    h0 = hs_cnt;
    send_byte("F");
    send_byte("1");
    send_byte("0");
    send_byte("0");
    send_byte("0");
    rx_data = 8'h0A;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    check("lat N update", 32'(cfg_update), 0);
    check("lat N freq", 32'(cfg_freq), 1);
    check("lat N tx_valid", 32'(tx_valid), 0);
    tick(1);
    check("lat N+1 freq", 32'(cfg_freq), 1000);
    check("lat N+1 update", 32'(cfg_update), 1);
    check("lat N+1 tx_valid", 32'(tx_valid), 1);
    check("lat N+1 tx_data", 32'(tx_data), 32'h4B);
    tick(1);
    check("lat N+2 update", 32'(cfg_update), 0);
    check("lat N+2 tx_valid", 32'(tx_valid), 0);
    tick(4);
    check("lat updates", upd_cnt - u0, 1);
    check("lat handshakes", hs_cnt - h0, 1);
    check_cfg("lat", 0, 1000, 15, 0);
    for (int i = 0; i < 15; i++) apply(tbl[i]);
    h0 = hs_cnt;
    u0 = upd_cnt;
    send_byte("F");
    send_byte("5");
    tick(TO + 10);
    check("timeout handshakes", hs_cnt - h0, 0);
    check("timeout updates", upd_cnt - u0, 0);
    apply('{"A3\n", 1, 8'h4B, 1, 4, 4095, 3, 255});
    tx_ready = 1'b0;
    h0 = hs_cnt;
    send_byte("W");
    send_byte("2");
    send_byte(8'h0A);
    check("bp tx_valid", 32'(tx_valid), 1);
    check("bp tx_data", 32'(tx_data), 32'h4B);
    check("bp wave", 32'(cfg_wave), 2);
    check("bp rx_drop before", 32'(rx_drop), 0);
    send_byte("A");
    check("bp rx_drop", 32'(rx_drop), 1);
    check("bp tx_valid held", 32'(tx_valid), 1);
    tick(5);
    check("bp no handshake", hs_cnt - h0, 0);
    tx_ready = 1'b1;
    tick(3);
    check("bp handshakes", hs_cnt - h0, 1);
    check("bp tx_valid drop", 32'(tx_valid), 0);
    apply('{"R\n", 1, 8'h4B, 1, 0, 1, 15, 0});
    check("rx_drop sticky", 32'(rx_drop), 1);
    apply('{"W3\n", 1, 8'h4B, 1, 3, 1, 15, 0});
    send_byte("F");
    send_byte("7");
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    check_cfg("midrst", 0, 1, 15, 0);
    check("midrst rx_drop", 32'(rx_drop), 0);
    check("midrst tx_valid", 32'(tx_valid), 0);
    apply('{"A9\n", 1, 8'h4B, 1, 0, 1, 9, 0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/awg_cmd_ctrl.md
Name: awg_cmd_ctrl

Overview:
- Clocked command controller for the AWG. Accepts UART receive bytes and parses framed ASCII commands (key letter, decimal digits, terminator).
- Range-checks each value, then commits it atomically to the waveform, frequency, amplitude and phase configuration registers that drive the DDS datapath.
- Returns a one-byte ACK/NAK over the UART transmit handshake.
- Replaces free-running digit shifting with validated, per-field updates.

Parameters:
- NUM_WAVES, 5, valid waveform indices are 0..NUM_WAVES-1 (max 8)
- DEF_WAVE, 0, reset/'R' value of cfg_wave
- DEF_FREQ, 1, reset/'R' value of cfg_freq
- DEF_AMP, 15, reset/'R' value of cfg_amp
- DEF_PHASE, 0, reset/'R' value of cfg_phase
- TIMEOUT_CYC, 5000000, idle cycles mid-frame before silent abort (100 ms at 50 MHz)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  received byte, valid when rx_valid=1
- rx_valid  in  1  one-cycle strobe, already synchronous to clk
- tx_data  out  8  response byte: "K" (0x4B) or "E" (0x45)
- tx_valid  out  1  response pending; held until tx_ready
- tx_ready  in  1  UART transmitter accepts tx_data when tx_valid&tx_ready
- cfg_wave  out  3  waveform select
- cfg_freq  out  12  frequency word, 1..4095
- cfg_amp  out  4  amplitude, 0..15
- cfg_phase  out  8  phase offset, 0..255
- cfg_update  out  1  one-cycle pulse on any committed change
- rx_drop  out  1  sticky: a byte arrived while in RESP; cleared by rst only

Behaviour:
- One clock domain. Reset is synchronous and active-high.
  - Reset values: cfg_* = DEF_*, tx_valid=0, tx_data=0, cfg_update=0, rx_drop=0, FSM=IDLE, accumulator=0, digit count=0, timeout counter=0.
- Frame format: key in {"W","F","A","P","R"} (uppercase only), then digits "0".."9", then terminator CR (0x0D) or LF (0x0A).
- Digit limits per key: W 1, F 4, A 2, P 3, R 0. Leading zeros count toward the limit.
- Accumulator: 14-bit unsigned, acc <= acc*10 + (byte-0x30). It cannot overflow within the digit limits (max 9999).
- FSM states:
  - IDLE:
    - Valid key byte: latch key, clear acc and digit count, go to DIGITS.
    - Terminator: ignored; stay in IDLE.
    - Any other byte: go to DISCARD.
  - DIGITS:
    - Digit byte with count < limit: accumulate.
    - Digit byte with count = limit: go to DISCARD.
    - Terminator: go to CHECK.
    - Any other byte: go to DISCARD.
  - DISCARD: drop bytes until a terminator, then go to RESP with "E".
  - CHECK (one cycle): pass/fail rules per key:
    - W: 0 <= acc < NUM_WAVES
    - F: 1..4095
    - A: 0..15
    - P: 0..255
    - R: zero digits
    - Any key other than R with zero digits: fail.
    - Pass: write the field (R writes all four DEF_*), pulse cfg_update, load "K".
    - Fail: outputs unchanged, load "E".
    - Both cases: tx_valid=1, go to RESP.
  - RESP: hold tx_data/tx_valid. On tx_valid&tx_ready, drop tx_valid and go to IDLE the same edge. An rx_valid in RESP is discarded and sets rx_drop.
- Commit of an identical value still pulses cfg_update and ACKs.
- Latency:
  - Terminator accepted at edge N: CHECK runs in cycle N..N+1.
  - At edge N+1, cfg_*, cfg_update=1 and tx_valid=1 are all visible together.
  - cfg_update deasserts at edge N+2.
- Timeout:
  - In DIGITS or DISCARD, the counter increments each cycle without rx_valid and clears on rx_valid.
  - At TIMEOUT_CYC, return to IDLE silently: no response, no commit.
  - The counter is held at 0 in IDLE/CHECK/RESP.
- rst asserted mid-frame or in RESP: abort immediately to reset values. A pending response is lost.
- rx_valid arriving in the same cycle as CHECK is impossible by construction: CHECK immediately follows a byte, and the UART byte spacing is ≥ 2 cycles. Any byte arriving in CHECK is treated as dropped and sets rx_drop.

Decomposition:
- Shared package awg_pkg:
  - ASCII constants: KEY_W/F/A/P/R, CR, LF, ACK "K", NAK "E"
  - FSM state enum
  - Field widths: WAVE_W=3, FREQ_W=12, AMP_W=4, PHASE_W=8
  - Per-key digit-limit and max-value constants
- One natural sub-module, awg_dec_acc: digit decode plus acc*10 accumulate with digit counter and limit flag. FSM, range check, cfg registers and tx handshake stay in awg_cmd_ctrl.

Test Plan:
- Reset, then idle 10 cycles -> cfg_wave=0, cfg_freq=1, cfg_amp=15, cfg_phase=0, tx_valid=0, cfg_update=0.
- Bytes "F","1","0","0","0",LF with tx_ready=1 -> cfg_freq=1000 two edges after LF, single cfg_update pulse, tx_data=0x4B for one handshake; other fields unchanged.
- "A","1","6",CR -> tx_data=0x45, cfg_amp stays 15, no cfg_update. "W","5",CR with NUM_WAVES=5 -> "E". "F","0",CR -> "E".
- "P","1","2","3","4",LF (excess digit) and "P","x",LF -> "E" each, cfg_phase unchanged. Then "P","2","5","5",LF -> cfg_phase=255, "K".
- "F","5" then no bytes for TIMEOUT_CYC cycles, then "A","3",LF -> no response for the F frame, cfg_freq unchanged, cfg_amp=3 with "K".
- Hold tx_ready=0 after "W","2",LF, send "A" during RESP -> rx_drop=1, tx_valid held. Release tx_ready -> one handshake, back to IDLE. Then "R",LF -> all cfg_* return to DEF_*, "K".
